seq_chunk_rca: RTL
==================

// Module: seq_chunk_rca
// PURPOSE
//  Multi-cycle ripple-carry adder: adds two WIDTH-bit operands plus carry-in,
//  CHUNK bits per clock, through a CHUNK-bit full-adder ripple chain.
//  Parametrised, sequential successor to the 4-bit combinational RCA.
//  Trades latency for a short carry path; start/busy/done handshake to the datapath.
// PARAMETERS
//  WIDTH   16  operand and sum width in bits
//  CHUNK   4   bits added per cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  NCHUNK  WIDTH/CHUNK  localparam: number of ADD cycles
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      asynchronous reset, active-high
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A, sampled with accepted start
//  b      in   WIDTH  operand B, sampled with accepted start
//  cin    in   1      carry-in, sampled with accepted start
//  busy   out  1      high while in ADD state
//  done   out  1      one-cycle pulse: result valid
//  sum    out  WIDTH  registered result
//  cout   out  1      registered carry-out of MSB
//  ovf    out  1      signed overflow (only with RCA_OVF_EN)
// BEHAVIOUR
//  - Reset (any time, incl. mid-op): state=IDLE, busy=0, done=0, sum=0, cout=0,
//    ovf=0, working regs and chunk index cleared; in-flight operation discarded.
//  - FSM: IDLE -start-> ADD; ADD -(idx==NCHUNK-1)-> DONE; DONE -start-> ADD;
//    DONE -!start-> IDLE.
//  - Accept: start=1 in IDLE or DONE latches a, b, cin into working regs,
//    idx=0, carry reg=cin. start during ADD is ignored (no queueing).
//  - ADD cycle idx: chunk [idx*CHUNK +: CHUNK] of A, B plus carry reg through
//    CHUNK ripple full adders; chunk result into working sum; carry reg takes
//    chunk carry-out; idx++.
//  - On last ADD edge: sum <= full working sum, cout <= final carry; state=DONE.
//  - Latency: start accepted at edge E0 -> done=1 in the cycle after edge E0+NCHUNK.
//    busy=1 for exactly NCHUNK cycles; done and busy never both high.
//  - sum/cout/ovf change only on the last ADD edge and hold stable until the next
//    completion or reset. Partial results are never visible.
//  - Back-to-back: start in DONE cycle accepted; done still pulses that cycle;
//    next done NCHUNK+1 cycles after the previous one.
//  - Arithmetic is unsigned mod 2^WIDTH. {cout,sum} == a+b+cin exactly.
//  - CHUNK==WIDTH legal: NCHUNK=1, done one cycle after one ADD cycle.
// CONFIGURATION
//  RCA_OVF_EN defined: port ovf present; ovf = carry into MSB XOR carry out of MSB
//    (two's-complement overflow), registered with sum/cout.
//  RCA_OVF_EN undefined: ovf port and its logic absent; all else identical.
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//  1. a=16'h000A, b=16'h000B, cin=1, start 1 cycle -> busy 4 cycles, then done
//     pulse; sum=16'h0016, cout=0.
//  2. a=16'hFFFF, b=16'h0000, cin=1 -> carry ripples all 4 chunks; sum=16'h0000,
//     cout=1.
//  3. start a=1,b=1; start again during ADD with a=16'h00FF -> ignored;
//     single done, sum=16'h0002.
//  4. rst pulsed during 2nd ADD cycle -> all outputs 0, IDLE, no done;
//     next start a=3,b=4 -> sum=7.
//  5. start held high through DONE with new a=16'h1234, b=16'h4321 -> accepted;
//     second done 5 cycles later, sum=16'h5555.
//  6. RCA_OVF_EN: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, ovf=1, cout=0;
//     a=16'hFFFF, b=16'h0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/seq_chunk_rca.sv
// Multi-cycle ripple-carry adder: WIDTH-bit operands summed CHUNK bits per clock.
// Optional signed-overflow output enabled by defining RCA_OVF_EN.
module seq_chunk_rca #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_chunk_rca: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg, work_sum, work_next;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
    logic [CHUNK:0]    c;
    logic              accept, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == LAST_IDX);
    assign busy   = (state == ADD);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last)  state_next = DONE;
            DONE:    state_next = start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the active chunk, ripple it, and merge the result into the working sum.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
        c       = '0;
        s_chunk = '0;
        c[0]    = carry;
        for (int j = 0; j < CHUNK; j++) begin
            s_chunk[j] = a_chunk[j] ^ b_chunk[j] ^ c[j];
            c[j+1]     = (a_chunk[j] & b_chunk[j]) | (c[j] & (a_chunk[j] ^ b_chunk[j]));
        end
        work_next = work_sum;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) work_next[i*CHUNK +: CHUNK] = s_chunk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            work_sum <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
        end else if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            work_sum <= '0;
            carry    <= cin;
            idx      <= '0;
        end else if (state == ADD) begin
            work_sum <= work_next;
            carry    <= c[CHUNK];
            idx      <= last ? '0 : idx + 1'b1;
            if (last) begin
                sum  <= work_next;
                cout <= c[CHUNK];
            end
        end
    end

`ifdef RCA_OVF_EN
    // On the last chunk, c[CHUNK-1] is the carry into the operand MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 ovf <= 1'b0;
        else if (!accept && state == ADD && last) ovf <= c[CHUNK-1] ^ c[CHUNK];
    end
`endif

endmodule
